// File: rtl/cook_alarm_beeper.sv
// cook_alarm_beeper: beep-pattern alarm tone generator; `COOK_ALARM_AUTO_OFF_EN enables auto-off after MAX_GROUPS groups.
module cook_alarm_beeper #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TONE_HZ    = 2_000,
  parameter int BEEP_MS    = 200,
  parameter int GAP_MS     = 150,
  parameter int BEEPS      = 3,
  parameter int PAUSE_MS   = 1000,
  parameter int MAX_GROUPS = 20
) (
  input  logic clk,
  input  logic reset_p,
  input  logic alarm_start,
  input  logic alarm_stop,
  output logic buzzer,
  output logic led_alarm,
  output logic busy,
  output logic done
);
  localparam int HALF   = CLK_HZ / (2 * TONE_HZ);
  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int MAX_MS = BEEP_MS > GAP_MS ? (BEEP_MS > PAUSE_MS ? BEEP_MS : PAUSE_MS) : (GAP_MS > PAUSE_MS ? GAP_MS : PAUSE_MS);
  localparam int PW = MS_CYC > 1 ? $clog2(MS_CYC) : 1;
  localparam int MW = MAX_MS > 1 ? $clog2(MAX_MS) : 1;
  localparam int HW = HALF > 1 ? $clog2(HALF) : 1;
  localparam int BW = $clog2(BEEPS + 1);
  if (HALF < 1 || BEEPS < 1 || BEEPS > 15 || MAX_GROUPS < 1 || MAX_GROUPS > 255) begin : g_bad_param
    $error("cook_alarm_beeper: parameter out of range");
  end
  typedef enum logic [1:0] {IDLE, TONE, GAP, PAUSE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q;
  logic [MW-1:0] ms_q, lim;
  logic [HW-1:0] half_q;
  logic [BW-1:0] beep_q, beep_d;
  logic tone_q, led_q, busy_q, tick, expire, enter;
`ifdef COOK_ALARM_AUTO_OFF_EN
  localparam int GW = MAX_GROUPS > 1 ? $clog2(MAX_GROUPS) : 1;
  logic [GW-1:0] grp_q, grp_d;
  logic done_q, done_d;
  assign done = done_q;
`else
  assign done = 1'b0;
`endif
  assign buzzer    = tone_q;
  assign led_alarm = led_q;
  assign busy      = busy_q;
  always_comb begin
    tick   = pre_q == PW'(MS_CYC - 1);
    lim    = state_q == TONE ? MW'(BEEP_MS - 1) : state_q == GAP ? MW'(GAP_MS - 1) : MW'(PAUSE_MS - 1);
    expire = state_q != IDLE && tick && ms_q == lim;
    state_d = state_q;
    beep_d  = beep_q;
    enter   = 1'b0;
`ifdef COOK_ALARM_AUTO_OFF_EN
    grp_d  = grp_q;
    done_d = 1'b0;
`endif
    if (alarm_stop) begin
      state_d = IDLE;
      enter   = 1'b1;
    end else if (alarm_start) begin
      state_d = TONE;
      beep_d  = '0;
      enter   = 1'b1;
`ifdef COOK_ALARM_AUTO_OFF_EN
      grp_d = '0;
`endif
    end else if (expire) begin
      enter = 1'b1;
      if (state_q == TONE) begin
        beep_d  = beep_q + BW'(1);
        state_d = int'(beep_q) + 1 < BEEPS ? GAP : PAUSE;
      end else if (state_q == GAP) begin
        state_d = TONE;
      end else begin
        state_d = TONE;
        beep_d  = '0;
`ifdef COOK_ALARM_AUTO_OFF_EN
        grp_d = grp_q + GW'(1);
        if (int'(grp_q) + 1 == MAX_GROUPS) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= IDLE;
      pre_q   <= '0;
      ms_q    <= '0;
      half_q  <= '0;
      beep_q  <= '0;
      tone_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef COOK_ALARM_AUTO_OFF_EN
      grp_q  <= '0;
      done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beep_q  <= beep_d;
      led_q   <= state_d == TONE;
      busy_q  <= state_d != IDLE;
`ifdef COOK_ALARM_AUTO_OFF_EN
      grp_q  <= grp_d;
      done_q <= done_d;
`endif
      // Every state entry restarts the interval and tone phase so intervals are exact.
      if (enter || state_d == IDLE) begin
        pre_q  <= '0;
        ms_q   <= '0;
        half_q <= '0;
        tone_q <= state_d == TONE;
      end else begin
        pre_q  <= tick ? '0 : pre_q + PW'(1);
        ms_q   <= tick ? ms_q + MW'(1) : ms_q;
        half_q <= half_q == HW'(HALF - 1) ? '0 : half_q + HW'(1);
        tone_q <= state_q == TONE && (half_q == HW'(HALF - 1) ? ~tone_q : tone_q);
      end
    end
  end
endmodule

// File: tb/tb_cook_alarm_beeper.sv
// tb_cook_alarm_beeper: directed and random stimulus checked against a time-since-start beep-pattern model.
module tb_cook_alarm_beeper;
  localparam int BEEP_C  = 20;
  localparam int GAP_C   = 10;
  localparam int PAUSE_C = 30;
  localparam int BEEPS   = 2;
  localparam int HALF    = 5;
  localparam int GROUPS  = 2;
  localparam int PERIOD  = BEEPS * BEEP_C + (BEEPS - 1) * GAP_C + PAUSE_C;
`ifdef COOK_ALARM_AUTO_OFF_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0, reset_p = 1'b1, alarm_start = 1'b0, alarm_stop = 1'b0;
  logic buzzer, led_alarm, busy, done;
  int n_chk = 0, n_pass = 0;
  bit act = 1'b0;
  int t = 0;
  bit exp_done;
  cook_alarm_beeper #(
    .CLK_HZ(10_000), .TONE_HZ(1_000), .BEEP_MS(2), .GAP_MS(1),
    .BEEPS(BEEPS), .PAUSE_MS(3), .MAX_GROUPS(GROUPS)
  ) dut (
    .clk(clk), .reset_p(reset_p), .alarm_start(alarm_start), .alarm_stop(alarm_stop),
    .buzzer(buzzer), .led_alarm(led_alarm), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at t=%0d active=%0d: got %b expected %b", tag, t, act, got, exp);
  endtask
  task automatic step(input bit s, input bit p, input bit r);
    int ph, k, off;
    bit in_tone;
    @(negedge clk);
    alarm_start = s;
    alarm_stop  = p;
    reset_p     = r;
    @(posedge clk);
    exp_done = 1'b0;
    if (r || p) act = 1'b0;
    else if (s) begin
      act = 1'b1;
      t   = 0;
    end else if (act) begin
      t++;
      if (AUTO && t == GROUPS * PERIOD) begin
        act      = 1'b0;
        exp_done = 1'b1;
      end
    end
    ph      = t % PERIOD;
    k       = ph / (BEEP_C + GAP_C);
    off     = ph % (BEEP_C + GAP_C);
    in_tone = act && k < BEEPS && off < BEEP_C;
    #1;
    check("busy", busy, act);
    check("led_alarm", led_alarm, in_tone);
    check("buzzer", buzzer, in_tone && ((off / HALF) % 2 == 0));
    check("done", done, exp_done);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    idle(400);
    step(1'b1, 1'b0, 1'b0);
    idle(8);
    step(1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0);
    idle(24);
    step(1'b1, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(60);
    step(1'b1, 1'b0, 1'b0);
    idle(45);
    step(1'b1, 1'b0, 1'b0);
    idle(23);
    step(1'b0, 1'b0, 1'b1);
    idle(500);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(149) == 0, $urandom_range(199) == 0, $urandom_range(599) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cook_alarm_beeper.md
# cook_alarm_beeper

Alarm sound generator placed directly downstream of the cook timer. Consumes the timer's one-cycle "time expired" pulse and drives the buzzer with a square-wave tone gated into a beep pattern: groups of short beeps separated by a longer pause. Any front-panel button stops it. An optional auto-off limit ends the alarm after a fixed number of beep groups. Replaces the timer's raw level-driven buzzer output.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz
- `TONE_HZ`, 2_000, buzzer tone frequency; `HALF = CLK_HZ/(2*TONE_HZ)` cycles per half-period, integer, ≥1
- `BEEP_MS`, 200, tone-on time per beep
- `GAP_MS`, 150, silence between beeps inside a group
- `BEEPS`, 3, beeps per group (1..15)
- `PAUSE_MS`, 1000, silence after each group
- `MAX_GROUPS`, 20, groups before auto-off (1..255; used only with the auto-off feature)

Ports:
- `clk`, in, 1, system clock; all logic on rising edge
- `reset_p`, in, 1, reset, synchronous, active-high
- `alarm_start`, in, 1, one-cycle pulse from the timer at expiry
- `alarm_stop`, in, 1, level or pulse: OR of all debounced buttons
- `buzzer`, out, 1, registered tone output to the piezo
- `led_alarm`, out, 1, registered; high during each beep's tone-on window
- `busy`, out, 1, registered; high in any state except IDLE
- `done`, out, 1, one-cycle pulse when auto-off ends the alarm

## Operation
- Millisecond tick: prescaler counts `CLK_HZ/1000` cycles. It is cleared on every state entry so that every interval is exactly `N_MS*CLK_HZ/1000` cycles.
- State machine: IDLE, TONE, GAP, PAUSE.
  - IDLE, `alarm_start`=1 → TONE. Clear beep count and group count.
  - TONE, `BEEP_MS` elapsed → GAP if fewer than `BEEPS` beeps are complete, otherwise PAUSE. The beep count increments on leaving TONE.
  - GAP, `GAP_MS` elapsed → TONE.
  - PAUSE, `PAUSE_MS` elapsed → TONE, clear beep count, increment group count.
  - In any non-IDLE state, `alarm_stop`=1 → IDLE.
- Tone: internal square wave `tone_q`.
  - Set to 1 on every entry into TONE.
  - Toggles every `HALF` cycles while in TONE.
  - Forced to 0 outside TONE.
  - `buzzer` = `tone_q`.
- `led_alarm`=1 exactly while the state is TONE.
- Priority, highest first: `reset_p` > `alarm_stop` > `alarm_start` > interval expiry.
  - `alarm_start` while not IDLE retriggers: state becomes TONE and both counters clear.
  - `alarm_start` and `alarm_stop` in the same cycle: stop wins and the state goes to IDLE.
- `alarm_stop` held high keeps the block in IDLE, and `alarm_start` is ignored while it is high.
- Counters are sized with `$clog2` of their maximum value. No counter wraps: each is cleared on state entry.

## Timing
- Reset (synchronous): on the first rising edge with `reset_p`=1, the state becomes IDLE, all counters are 0, and `buzzer`, `led_alarm`, `busy` and `done` are 0. Reset mid-alarm silences the buzzer on that same edge.
- Start latency: `alarm_start` sampled high at edge k → `buzzer`=1, `led_alarm`=1 and `busy`=1 after edge k.
- Stop latency: `alarm_stop` sampled high at edge k → all outputs 0 after edge k (`done` stays 0).
- The first `buzzer` toggle occurs `HALF` cycles after TONE entry.
- Each TONE lasts exactly `BEEP_MS*CLK_HZ/1000` cycles; GAP and PAUSE follow the same rule with their own parameters.
- Group period = `BEEPS*BEEP + (BEEPS-1)*GAP + PAUSE` ms.

## Configuration
- `COOK_ALARM_AUTO_OFF_EN` defined:
  - When a PAUSE completes and group count + 1 equals `MAX_GROUPS`, go to IDLE instead of TONE.
  - `done`=1 for exactly that one cycle, concurrent with `busy` falling.
- Not defined:
  - The alarm repeats until `alarm_stop` or reset.
  - `done` is tied to 0, the group counter is not built, and `MAX_GROUPS` is ignored.

## Test plan
All scenarios use `CLK_HZ`=10_000, `TONE_HZ`=1_000 (`HALF`=5), `BEEP_MS`=2 (20 cycles), `GAP_MS`=1 (10), `BEEPS`=2, `PAUSE_MS`=3 (30), `MAX_GROUPS`=2.
- Reset then idle, `alarm_start` pulse at edge 0 → `buzzer` high for edges 1–5, low for 6–10, and 2 full tone periods in the beep. `led_alarm` high for 20 cycles, then 10 cycles low, then a second 20-cycle beep.
- Pattern check → after the second beep, 30 silent cycles with `busy`=1, then a new TONE starts 80 cycles after the first TONE entry.
- `alarm_stop` pulse in the middle of a TONE → `buzzer`, `led_alarm` and `busy` all 0 on the next edge. A later `alarm_start` restarts the alarm.
- `alarm_start` and `alarm_stop` high in the same cycle while IDLE → the block stays IDLE. The same while in GAP → IDLE. `alarm_start` alone during PAUSE → TONE on the next edge with the beep count cleared.
- `COOK_ALARM_AUTO_OFF_EN` defined → `done` pulses once at cycle 160 after start and `busy` falls with it. Without the macro → beeping still active at cycle 400 and `done` never asserts.
- `reset_p` asserted in the middle of a GAP for 1 cycle → all outputs 0 after that edge. With no new start, no further `buzzer` activity for 500 cycles.
